// File: rtl/axim_write_control.sv
// AXI write master: on a start edge issues one AW request, BURST_LEN incrementing-pattern
// W beats from PATTERN_SEED, then accepts one B response; pulses done and keeps a sticky error.
module axim_write_control #(
  parameter int unsigned BURST_LEN    = 32,
  parameter logic [24:0] BASE_ADDR    = 25'd0,
  parameter logic [15:0] PATTERN_SEED = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_triger,
  input  logic        axi_awready_in,
  output logic        axi_awvalid_out,
  output logic [7:0]  axi_awlen_out,
  output logic [24:0] axi_awaddr_out,
  input  logic        axi_wready_in,
  output logic        axi_wvalid_out,
  output logic [15:0] axi_wdata_out,
  output logic        axi_wlast_out,
  input  logic        axi_bvalid_in,
  input  logic [1:0]  axi_bresp_in,
  output logic        axi_bready_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {WR_READY, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t      state, state_nxt;
  logic        trig_meta, trig_1d, trig_2d;
  logic        start_pulse_c;
  logic        awvalid_nxt, wvalid_nxt, wlast_nxt, bready_nxt;
  logic        busy_nxt, done_nxt, error_nxt;
  logic [15:0] wdata_nxt;
  logic [7:0]  beat_cnt, beat_cnt_nxt, beat_cnt_inc;

  assign axi_awlen_out  = LAST_BEAT;
  assign axi_awaddr_out = BASE_ADDR;
  assign start_pulse_c  = trig_1d & ~trig_2d;
  assign beat_cnt_inc   = 8'(beat_cnt + 8'd1);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_meta       <= 1'b0;
      trig_1d         <= 1'b0;
      trig_2d         <= 1'b0;
      state           <= WR_READY;
      axi_awvalid_out <= 1'b0;
      axi_wvalid_out  <= 1'b0;
      axi_wlast_out   <= 1'b0;
      axi_wdata_out   <= PATTERN_SEED;
      axi_bready_out  <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
      beat_cnt        <= 8'd0;
    end else begin
      trig_meta       <= start_triger;
      trig_1d         <= trig_meta;
      trig_2d         <= trig_1d;
      state           <= state_nxt;
      axi_awvalid_out <= awvalid_nxt;
      axi_wvalid_out  <= wvalid_nxt;
      axi_wlast_out   <= wlast_nxt;
      axi_wdata_out   <= wdata_nxt;
      axi_bready_out  <= bready_nxt;
      busy_out        <= busy_nxt;
      done_out        <= done_nxt;
      error_out       <= error_nxt;
      beat_cnt        <= beat_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    awvalid_nxt  = axi_awvalid_out;
    wvalid_nxt   = axi_wvalid_out;
    wlast_nxt    = axi_wlast_out;
    wdata_nxt    = axi_wdata_out;
    bready_nxt   = axi_bready_out;
    done_nxt     = 1'b0;
    error_nxt    = error_out;
    beat_cnt_nxt = beat_cnt;

    case (state)
      WR_READY: begin
        if (start_pulse_c) begin
          awvalid_nxt = 1'b1;
          state_nxt   = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (axi_awvalid_out && axi_awready_in) begin
          awvalid_nxt  = 1'b0;
          wvalid_nxt   = 1'b1;
          wdata_nxt    = PATTERN_SEED;
          wlast_nxt    = (LAST_BEAT == 8'd0);
          beat_cnt_nxt = 8'd0;
          state_nxt    = WR_DATA;
        end
      end
      WR_DATA: begin
        if (axi_wvalid_out && axi_wready_in) begin
          if (!axi_wlast_out) begin
            beat_cnt_nxt = beat_cnt_inc;
            wdata_nxt    = 16'(axi_wdata_out + 16'd1);
            wlast_nxt    = (beat_cnt_inc == LAST_BEAT);
          end else begin
            wvalid_nxt = 1'b0;
            wlast_nxt  = 1'b0;
            bready_nxt = 1'b1;
            state_nxt  = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (axi_bvalid_in && axi_bready_out) begin
          bready_nxt = 1'b0;
          done_nxt   = 1'b1;
          error_nxt  = error_out | (axi_bresp_in != 2'b00);
          state_nxt  = WR_READY;
        end
      end
      default: state_nxt = WR_READY;
    endcase

    // busy is registered alongside the state so it tracks state != WR_READY exactly
    busy_nxt = (state_nxt != WR_READY);
  end

endmodule

// File: tb/tb_axim_write_control.sv
// Randomized bench for axim_write_control: three instances (default, wrapping seed, single beat)
// driven by a stalling slave and checked against a beat-index scoreboard.
module tb_axim_write_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_t   [3];
  logic        awready   [3];
  logic        awvalid   [3];
  logic [7:0]  awlen     [3];
  logic [24:0] awaddr    [3];
  logic        wready    [3];
  logic        wvalid    [3];
  logic [15:0] wdata     [3];
  logic        wlast     [3];
  logic        bvalid    [3];
  logic [1:0]  bresp     [3];
  logic        bready    [3];
  logic        busy      [3];
  logic        done      [3];
  logic        error     [3];

  int n_chk  = 0;
  int n_pass = 0;
  bit err_exp [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axim_write_control #(
      .BURST_LEN   ((g == 2) ? 1 : 32),
      .BASE_ADDR   ((g == 2) ? 25'h1ABCDE : 25'd0),
      .PATTERN_SEED((g == 1) ? 16'hFFFE : (g == 2) ? 16'h1234 : 16'h0000)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .start_triger   (start_t[g]),
      .axi_awready_in (awready[g]),
      .axi_awvalid_out(awvalid[g]),
      .axi_awlen_out  (awlen[g]),
      .axi_awaddr_out (awaddr[g]),
      .axi_wready_in  (wready[g]),
      .axi_wvalid_out (wvalid[g]),
      .axi_wdata_out  (wdata[g]),
      .axi_wlast_out  (wlast[g]),
      .axi_bvalid_in  (bvalid[g]),
      .axi_bresp_in   (bresp[g]),
      .axi_bready_out (bready[g]),
      .busy_out       (busy[g]),
      .done_out       (done[g]),
      .error_out      (error[g])
    );
  end

  function automatic int blen(input int i);
    return (i == 2) ? 1 : 32;
  endfunction

  function automatic logic [15:0] seedv(input int i);
    return (i == 1) ? 16'hFFFE : (i == 2) ? 16'h1234 : 16'h0000;
  endfunction

  function automatic logic [24:0] basev(input int i);
    return (i == 2) ? 25'h1ABCDE : 25'd0;
  endfunction

  task automatic check_reset_state(input int i, input string tag);
    n_chk++; if ({awvalid[i], wvalid[i], wlast[i], bready[i]} !== 4'b0000)
      $display("FAIL %s[%0d] handshake outs=%b%b%b%b want 0000", tag, i, awvalid[i], wvalid[i], wlast[i], bready[i]);
    else n_pass++;
    n_chk++; if ({busy[i], done[i], error[i]} !== 3'b000)
      $display("FAIL %s[%0d] busy/done/error=%b%b%b want 000", tag, i, busy[i], done[i], error[i]);
    else n_pass++;
    n_chk++; if (wdata[i] !== seedv(i))
      $display("FAIL %s[%0d] wdata=%h want %h", tag, i, wdata[i], seedv(i));
    else n_pass++;
  endtask

  // One burst on instance i against a slave stalling stall% of the time; called at a negedge.
  task automatic run_burst(input int i, input int stall, input logic [1:0] resp,
                           input int abort_at, input bit extra_starts);
    int bl = blen(i);
    int k = 0, aw_hs = 0, cyc = 0;
    bit fin = 0;
    bresp[i] = resp;
    while (cyc < 3000) begin
      start_t[i] = (cyc < 2) || (extra_starts && cyc < 20 && (cyc % 5) < 2);
      if (awvalid[i]) begin
        n_chk++; if (awaddr[i] !== basev(i) || awlen[i] !== 8'(bl - 1) || wvalid[i] !== 1'b0)
          $display("FAIL aw[%0d] addr=%h len=%0d wvalid=%b want %h %0d 0", i, awaddr[i], awlen[i], wvalid[i], basev(i), bl - 1);
        else n_pass++;
      end
      if (wvalid[i]) begin
        n_chk++; if (wdata[i] !== 16'(seedv(i) + 16'(k)) || wlast[i] !== (k == bl - 1) || busy[i] !== 1'b1)
          $display("FAIL beat[%0d] k=%0d data=%h last=%b busy=%b want %h %b 1", i, k, wdata[i], wlast[i], busy[i], 16'(seedv(i) + 16'(k)), (k == bl - 1));
        else n_pass++;
      end
      if (abort_at >= 0 && wvalid[i] && k == abort_at) begin
        start_t[i] = 1'b0;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_state(i, "abort");
        reset = 1'b0;
        for (int j = 0; j < 3; j++) err_exp[j] = 1'b0;
        awready[i] = 1'b0; wready[i] = 1'b0; bvalid[i] = 1'b0;
        for (int c = 0; c < 8; c++) begin
          @(posedge clk); @(negedge clk);
          n_chk++; if (done[i] !== 1'b0 || busy[i] !== 1'b0)
            $display("FAIL abort_idle[%0d] done=%b busy=%b want 0 0", i, done[i], busy[i]);
          else n_pass++;
        end
        return;
      end
      if (done[i]) begin
        n_chk++; if (k !== bl || aw_hs !== 1)
          $display("FAIL done_count[%0d] beats=%0d aw=%0d want %0d 1", i, k, aw_hs, bl);
        else n_pass++;
        n_chk++; if (error[i] !== err_exp[i] || busy[i] !== 1'b0)
          $display("FAIL done_state[%0d] error=%b busy=%b want %b 0", i, error[i], busy[i], err_exp[i]);
        else n_pass++;
        if (stall == 0) begin
          n_chk++; if (cyc !== bl + 5)
            $display("FAIL latency[%0d] cycles=%0d want %0d", i, cyc, bl + 5);
          else n_pass++;
        end
        fin = 1;
        break;
      end
      awready[i] = ($urandom % 100) >= stall;
      wready[i]  = ($urandom % 100) >= stall;
      bvalid[i]  = bready[i] && (($urandom % 100) >= stall);
      if (awvalid[i] && awready[i]) aw_hs++;
      if (wvalid[i] && wready[i]) k++;
      if (bvalid[i] && bready[i]) err_exp[i] = err_exp[i] | (resp != 2'b00);
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    start_t[i] = 1'b0;
    awready[i] = 1'b0; wready[i] = 1'b0; bvalid[i] = 1'b0;
    n_chk++; if (!fin) $display("FAIL timeout[%0d] no done after %0d cycles", i, cyc);
    else n_pass++;
    // done is a single pulse and no dropped start may launch a queued burst
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      n_chk++; if (done[i] !== 1'b0 || awvalid[i] !== 1'b0 || busy[i] !== 1'b0)
        $display("FAIL post_done[%0d] done=%b awvalid=%b busy=%b want 0 0 0", i, done[i], awvalid[i], busy[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_state(i, "reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_wait();
    run_burst(0, 0, 2'b00, -1, 1'b0);
  endtask

  task automatic test_random_stalls();
    run_burst(1, 50, 2'b00, -1, 1'b0);
    run_burst(1, 50, 2'b00, -1, 1'b0);
  endtask

  task automatic test_error_sticky();
    run_burst(0, 0, 2'b10, -1, 1'b0);
    run_burst(0, 30, 2'b00, -1, 1'b0);
    n_chk++; if (error[0] !== 1'b1) $display("FAIL error_sticky error=%b want 1", error[0]);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    run_burst(0, 0, 2'b00, -1, 1'b1);
    run_burst(0, 0, 2'b00, -1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    run_burst(0, 0, 2'b00, 9, 1'b0);
    run_burst(0, 20, 2'b00, -1, 1'b0);
    n_chk++; if (error[0] !== 1'b0) $display("FAIL reset_clears_error error=%b want 0", error[0]);
    else n_pass++;
  endtask

  task automatic test_single_beat();
    run_burst(2, 0, 2'b00, -1, 1'b0);
    run_burst(2, 40, 2'b01, -1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_t[i] = 1'b0; awready[i] = 1'b0; wready[i] = 1'b0;
      bvalid[i] = 1'b0; bresp[i] = 2'b00; err_exp[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    test_reset();
    test_zero_wait();
    test_random_stalls();
    test_error_sticky();
    test_start_ignored();
    test_reset_mid_burst();
    test_single_beat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
